// File: rtl/vp_temporal_mac_array.sv
// Temporal MAC array: per-lane signed accumulators fed from an AXI-Stream slave,
// requantised to int8 with a shared scale/shift and streamed out in lane order.
module vp_temporal_mac_array #(
  parameter int AXIS_DW = 32,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic               SD_AXIS_TREADY,
  input  logic [AXIS_DW-1:0] SD_AXIS_TDATA,
  input  logic               SD_AXIS_TLAST,
  input  logic               SD_AXIS_TUSER,
  input  logic               SD_AXIS_TVALID,
  input  logic [7:0]         SD_AXIS_TID,
  output logic               MO_AXIS_TVALID,
  output logic [AXIS_DW-1:0] MO_AXIS_TDATA,
  output logic               MO_AXIS_TLAST,
  input  logic               MO_AXIS_TREADY,
  output logic [7:0]         MO_AXIS_TID,
  output logic               ERR
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PSW = 17;
  localparam int PW  = ACC_W + 18;

  typedef enum logic [2:0] {IDLE, CFG_SCALE, ACCUM, DRAIN, REQUANT, WR_OUT} state_t;

  state_t                    r_state;
  logic [1:0]                r_mode;
  logic [4:0]                r_shift;
  logic signed [15:0]        r_scale;
  logic                      r_err;
  logic signed [ACC_W-1:0]   r_acc [LANES];
  logic signed [7:0]         r_obuf [LANES];
  logic                      r_pValid;
  logic [LW-1:0]             r_pLane;
  logic signed [PSW-1:0]     r_pSum;
  logic                      r_drainCnt;
  logic [LW-1:0]             r_rqLane;
  logic [LW-1:0]             r_oLane;
  logic                      r_oValid;
  logic [AXIS_DW-1:0]        r_oData;
  logic                      r_oLast;
  logic [7:0]                r_oTid;

  logic                      w_sHs;
  logic                      w_laneOk;
  logic                      w_isData;
  logic                      w_dataOk;
  logic                      w_unused;
  logic [7:0]                w_act;
  logic [7:0]                w_wt;
  logic signed [PSW-1:0]     w_ea;
  logic signed [PSW-1:0]     w_eb;
  logic signed [PSW-1:0]     w_psum;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_rnd;
  logic signed [PW-1:0]      w_shifted;
  logic signed [7:0]         w_sat;

  assign SD_AXIS_TREADY = !RESET && (r_state == IDLE || r_state == CFG_SCALE || r_state == ACCUM);
  assign w_sHs    = SD_AXIS_TVALID && SD_AXIS_TREADY;
  assign w_laneOk = (32'(SD_AXIS_TID) < LANES);
  assign w_isData = w_sHs && !SD_AXIS_TUSER && (r_state == IDLE || r_state == ACCUM);
  assign w_dataOk = w_isData && w_laneOk;
  assign w_unused = ^SD_AXIS_TDATA;

  assign MO_AXIS_TVALID = r_oValid;
  assign MO_AXIS_TDATA  = r_oData;
  assign MO_AXIS_TLAST  = r_oLast;
  assign MO_AXIS_TID    = r_oTid;
  assign ERR            = r_err;

  // Sub-word dot product; mode 3 falls back to a single 8b pair.
  always_comb begin
    w_act  = SD_AXIS_TDATA[15:8];
    w_wt   = SD_AXIS_TDATA[7:0];
    w_ea   = '0;
    w_eb   = '0;
    w_psum = '0;
    case (r_mode)
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          w_ea   = PSW'($signed(w_act[4*i +: 4]));
          w_eb   = PSW'($signed(w_wt[4*i +: 4]));
          w_psum = w_psum + w_ea * w_eb;
        end
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) begin
          w_ea   = PSW'($signed(w_act[2*i +: 2]));
          w_eb   = PSW'($signed(w_wt[2*i +: 2]));
          w_psum = w_psum + w_ea * w_eb;
        end
      end
      default: begin
        w_ea   = PSW'($signed(w_act));
        w_eb   = PSW'($signed(w_wt));
        w_psum = w_ea * w_eb;
      end
    endcase
  end

  // Round-half-up requantisation of the lane currently selected by r_rqLane.
  always_comb begin
    w_prod    = PW'(r_acc[r_rqLane]) * PW'(r_scale);
    w_rnd     = (r_shift != 5'd0) ? (PW'(1) << (r_shift - 5'd1)) : '0;
    w_shifted = (w_prod + w_rnd) >>> r_shift;
    if (w_shifted > PW'(127))       w_sat = 8'h7F;
    else if (w_shifted < -PW'(128)) w_sat = 8'h80;
    else                            w_sat = w_shifted[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_mode     <= 2'd0;
      r_shift    <= 5'd0;
      r_scale    <= 16'sd1;
      r_err      <= 1'b0;
      r_pValid   <= 1'b0;
      r_pLane    <= '0;
      r_pSum     <= '0;
      r_drainCnt <= 1'b0;
      r_rqLane   <= '0;
      r_oLane    <= '0;
      r_oValid   <= 1'b0;
      r_oData    <= '0;
      r_oLast    <= 1'b0;
      r_oTid     <= 8'd0;
      for (int i = 0; i < LANES; i++) begin
        r_acc[i]  <= '0;
        r_obuf[i] <= '0;
      end
    end else begin
      r_pValid <= w_dataOk;
      if (w_dataOk) begin
        r_pLane <= SD_AXIS_TID[LW-1:0];
        r_pSum  <= w_psum;
      end
      if (r_pValid) r_acc[r_pLane] <= r_acc[r_pLane] + ACC_W'(r_pSum);
      if (w_isData && (!w_laneOk || r_mode == 2'd3)) r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_sHs) begin
            if (SD_AXIS_TUSER) begin
              r_mode  <= SD_AXIS_TDATA[1:0];
              r_shift <= SD_AXIS_TDATA[12:8];
              r_err   <= 1'b0;
              r_state <= CFG_SCALE;
            end else begin
              r_state <= SD_AXIS_TLAST ? DRAIN : ACCUM;
            end
          end
        end
        CFG_SCALE: begin
          if (w_sHs) begin
            r_scale <= SD_AXIS_TDATA[15:0];
            r_state <= SD_AXIS_TLAST ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (w_sHs) begin
            if (SD_AXIS_TUSER) r_err <= 1'b1;
            if (SD_AXIS_TLAST) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_drainCnt <= !r_drainCnt;
          if (r_drainCnt) begin
            r_rqLane <= '0;
            r_state  <= REQUANT;
          end
        end
        REQUANT: begin
          r_obuf[r_rqLane] <= w_sat;
          if (r_rqLane == LW'(LANES - 1)) begin
            r_rqLane <= '0;
            r_oLane  <= '0;
            r_state  <= WR_OUT;
          end else begin
            r_rqLane <= r_rqLane + LW'(1);
          end
        end
        WR_OUT: begin
          // One bubble cycle on entry, then each handshake loads the next lane.
          if (!r_oValid || MO_AXIS_TREADY) begin
            if (r_oValid && r_oLast) begin
              r_oValid <= 1'b0;
              r_oLast  <= 1'b0;
              r_oLane  <= '0;
              r_state  <= IDLE;
              for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
            end else begin
              r_oValid <= 1'b1;
              r_oData  <= AXIS_DW'(r_obuf[r_oLane]);
              r_oTid   <= 8'(r_oLane);
              r_oLast  <= (r_oLane == LW'(LANES - 1));
              r_oLane  <= r_oLane + LW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
